// File: rtl/tt_add_arb_pkg.sv
// Shared types and default constants for the shared-adder arbiter slice.
package tt_add_arb_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 8;
  localparam int unsigned IDW_DEF   = $clog2(N_REQ_DEF);

  // Result record at the default configuration: {carry, sum, id}.
  typedef struct packed {
    logic               carry;
    logic [W_DEF-1:0]   sum;
    logic [IDW_DEF-1:0] id;
  } add_res_t;

endpackage

// File: rtl/tt_rr_arbiter.sv
// Round-robin arbiter: remembers the last granted requester and grants the
// first valid requester after it. Grant is combinational and one-hot.
module tt_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic             taken,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx
);

  logic [IDW-1:0] last;
  logic [IDW-1:0] cand;
  logic           found;

  // Search from last+1 (wrapping) for the first valid requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (en) begin
      for (int unsigned i = 1; i <= N_REQ; i++) begin
        cand = IDW'((32'(last) + i) % N_REQ);
        if (!found && req[cand]) begin
          found        = 1'b1;
          gnt[cand]    = 1'b1;
          gnt_idx      = cand;
        end
      end
    end
  end

  // Pointer moves only on an accepted grant; reset gives requester 0 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDW'(N_REQ - 1);
    end else if (taken) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/tt_add_arbiter.sv
// Shares one registered W-bit adder among N_REQ requesters via round-robin
// arbitration, with a single-entry result register honouring backpressure.
// Optional: define ADD_ARB_SAT_EN for a saturating sum (carry still reported).
module tt_add_arbiter
  import tt_add_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_sum,
  output logic               res_carry,
  output logic [IDW-1:0]     res_id
);

  // Same shape as add_res_t, sized for this instance.
  typedef struct packed {
    logic           carry;
    logic [W-1:0]   sum;
    logic [IDW-1:0] id;
  } res_t;

  res_t             res_q;
  logic             valid_q;
  logic             take;
  logic             arb_en;
  logic             xfer;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic [W:0]       full_sum;
  logic [W-1:0]     sum_out;

  assign take   = !valid_q || res_ready;
  // Reset suppresses grants so no accept coincides with rst.
  assign arb_en = take && !rst;

  tt_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en),
    .taken   (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);

  // Operand mux and W+1-bit add for the granted requester.
  always_comb begin
    a_sel    = req_a[32'(gnt_idx)*W +: W];
    b_sel    = req_b[32'(gnt_idx)*W +: W];
    full_sum = {1'b0, a_sel} + {1'b0, b_sel};
`ifdef ADD_ARB_SAT_EN
    sum_out  = full_sum[W] ? '1 : full_sum[W-1:0];
`else
    sum_out  = full_sum[W-1:0];
`endif
  end

  // Result register: load on accept, drop valid on pop without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (xfer) begin
      valid_q     <= 1'b1;
      res_q.carry <= full_sum[W];
      res_q.sum   <= sum_out;
      res_q.id    <= gnt_idx;
    end else if (res_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign res_valid = valid_q;
  assign res_sum   = res_q.sum;
  assign res_carry = res_q.carry;
  assign res_id    = res_q.id;

endmodule

// File: doc/tt_add_arbiter.md
# tt_add_arbiter

Round-robin arbiter and sequencer that shares one registered W-bit adder among N_REQ requesters. Each requester presents an operand pair under a valid/ready handshake. One request is granted per cycle and its sum, carry and requester ID appear in a single-entry output register that honours downstream backpressure. The block sits between the project's input-side request sources and the shared adder result path in the tile's datapath.

## Interface
- N_REQ, 4: number of requesters; 2..8.
- W, 8: operand and sum width.
- IDW, $clog2(N_REQ): width of res_id.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*W  operand A; requester i uses bits [i*W +: W].
- req_b  in  N_REQ*W  operand B; same packing as req_a.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  W  registered sum.
- res_carry  out  1  registered carry-out of A+B.
- res_id  out  IDW  index of the requester that produced the result.

## Operation
- Slot free: `take = !res_valid || res_ready`.
- Grant: when take=1 and any req_valid is high, exactly one requester is granted. Search begins at (last+1) mod N_REQ and takes the first requester with valid=1.
- The req_ready bit of the granted requester is 1, combinationally from req_valid, res_valid, res_ready and the pointer. All other req_ready bits are 0. When take=0, every req_ready bit is 0.
- A transfer on requester i occurs when req_valid[i] and req_ready[i] are both high. On that edge:
  - res_sum and res_carry load {carry, sum} = A + B, computed at W+1 bits.
  - res_id loads i and res_valid is set to 1.
  - last is set to i.
- A cycle with res_ready=1, res_valid=1 and no grant clears res_valid. res_sum, res_carry and res_id keep their values.
- While res_valid=1 and res_ready=0, res_sum, res_carry and res_id stay stable.
- Requesters must hold req_valid, req_a and req_b stable until accepted. The block does not check this.
- last updates only on a grant. Idle cycles leave it unchanged.
- Fairness: a requester that holds req_valid high is granted within N_REQ grants.
- Unused high-order pointer encodings (N_REQ not a power of two) cannot occur.

## Timing
- Reset values:
  - res_valid=0, res_sum=0, res_carry=0, res_id=0.
  - last=N_REQ-1, so requester 0 has top priority first.
  - req_ready=0 while rst=1.
- Latency: a request accepted at edge k has its result visible with res_valid=1 after edge k.
- Throughput: one result per cycle while res_ready is held at 1 and requests are pending.
- Simultaneous pop and push: with res_valid=1 and res_ready=1, a grant in the same cycle replaces the result without a bubble.
- Reset during operation: the pending result is discarded and the pointer is restored. An accept that coincides with rst=1 is not performed.

## Configuration
- ADD_ARB_SAT_EN defined: saturating add. res_sum = carry ? {W{1'b1}} : sum. res_carry still reports the overflow.
- ADD_ARB_SAT_EN undefined: wrapping add, res_sum = (A+B) mod 2^W.

## Structure
- Package tt_add_arb_pkg holds:
  - default constants N_REQ_DEF=4 and W_DEF=8;
  - the result struct typedef {carry, sum, id}.
- Sub-module tt_rr_arbiter holds the round-robin pointer and the one-hot grant logic, parameterized by N_REQ. It takes req, en and a grant-taken input, and produces a one-hot grant and the granted index.
- The top level holds the operand mux, the adder, the saturation option and the output register.

## Test plan
- Reset, then single request: req0 with A=0x12, B=0x34 and res_ready=1 gives res_sum=0x46, res_carry=0, res_id=0 one cycle later. All outputs are 0 during rst.
- Overflow: A=0xF0, B=0x20. Without the macro, res_sum=0x10 and carry=1. With ADD_ARB_SAT_EN, res_sum=0xFF and carry=1.
- Round-robin: all four requesters valid continuously with res_ready=1. res_id sequence is 0,1,2,3,0, with no idle cycles and exactly one req_ready bit high per cycle.
- Backpressure: res_ready=0 for 3 cycles while req1 and req2 are valid. There are no grants, and res_sum and res_id stay stable. When res_ready rises, req1 is granted in the same cycle, with no bubble.
- Pointer retention: grant req2, idle for 5 cycles, then req0 and req3 assert together. req3 is granted first, then req0.
- Mid-operation reset: rst is asserted while res_valid=1 and requests are pending. The next cycle shows res_valid=0, and after release req0 wins over req1 and req2.
